// File: rtl/mem_sp_tiled_sky130.sv
`default_nettype none
// ============================================================================
// Module   : mem_sp_tiled_sky130
// Purpose  : Single-port SRAM tiled from 1RW macros, with handshake,
//            byte-enable read-modify-write, post-reset zero-fill and OOB flag.
// Revision : 1.0  initial release
// ============================================================================

// Behavioural 1RW macro: inputs sampled at posedge, array/dout update at negedge.
module mem_sp_tiled_sky130_macro #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             csb,
  input  logic             web,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic             r_csb;
  logic             r_web;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    r_csb  <= csb;
    r_web  <= web;
    r_addr <= addr;
    r_din  <= din;
  end

  always_ff @(negedge clk) begin
    if (!r_csb) begin
      if (!r_web) r_mem[r_addr] <= r_din;
      else        dout          <= r_mem[r_addr];
    end
  end
endmodule

module mem_sp_tiled_sky130 #(
  parameter int DATA_BIT    = 64,
  parameter int DEPTH       = 512,
  parameter int MACRO_WIDTH = 32,
  parameter int MACRO_DEPTH = 128,
  parameter int ADDR_BIT    = $clog2(DEPTH),
  parameter int INIT_ZERO   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  wen,
  input  logic [ADDR_BIT-1:0]   addr,
  input  logic [DATA_BIT-1:0]   wdata,
  input  logic [DATA_BIT/8-1:0] bwe,
  output logic [DATA_BIT-1:0]   rdata,
  output logic                  rvld,
  output logic                  init_done,
  output logic                  err_oob
);
  localparam int NCOL    = (DATA_BIT + MACRO_WIDTH - 1) / MACRO_WIDTH;
  localparam int NBANK   = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH;
  localparam int PAD     = NCOL * MACRO_WIDTH;
  localparam int NBYTE   = DATA_BIT / 8;
  localparam int ROW_BIT = $clog2(MACRO_DEPTH);
  localparam int BANK_W  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int CNT_W   = ROW_BIT + 1;

  localparam logic [ADDR_BIT:0] c_depth = (ADDR_BIT+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  c_rows  = CNT_W'(MACRO_DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RMW  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BANK_W-1:0]    r_bank;
  logic [ROW_BIT-1:0]   r_row;
  logic [DATA_BIT-1:0]  r_wdata;
  logic [NBYTE-1:0]     r_bwe;
  logic                 r_rd_pend;
  logic                 r_rd_oob;

  logic                 w_accept;
  logic                 w_oob;
  logic                 w_full;
  logic                 w_partial;
  logic [BANK_W-1:0]    w_bank;
  logic [ROW_BIT-1:0]   w_row_in;
  logic [DATA_BIT-1:0]  w_mask;
  logic [DATA_BIT-1:0]  w_dout_sel;
  logic [DATA_BIT-1:0]  w_merge;

  logic [NBANK-1:0]            w_csb;
  logic                        w_web;
  logic [ROW_BIT-1:0]          w_row;
  logic [PAD-1:0]              w_din;
  logic [NBANK-1:0][PAD-1:0]   w_bank_dout;

  assign w_oob     = ({1'b0, addr} >= c_depth);
  assign w_accept  = (r_state == S_IDLE) && req_vld && req_rdy;
  assign w_full    = &bwe;
  assign w_partial = (|bwe) && !w_full;
  assign w_bank    = BANK_W'(addr / MACRO_DEPTH);
  assign w_row_in  = ROW_BIT'(addr % MACRO_DEPTH);

  assign w_dout_sel = w_bank_dout[r_bank][DATA_BIT-1:0];
  assign w_merge    = (w_dout_sel & ~w_mask) | (r_wdata & w_mask);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NBYTE; i++) w_mask[i*8 +: 8] = {8{r_bwe[i]}};
  end

  // Macro drive is combinational from state/request; rst blocks every access so
  // an abandoned RMW can never land its merge.
  always_comb begin
    w_csb = '1;
    w_web = 1'b1;
    w_row = '0;
    w_din = '0;
    if (!rst) begin
      case (r_state)
        S_INIT: begin
          if (INIT_ZERO != 0 && r_cnt < c_rows) begin
            w_csb = '0;
            w_web = 1'b0;
            w_row = r_cnt[ROW_BIT-1:0];
          end
        end
        S_IDLE: begin
          if (w_accept && !w_oob) begin
            if (!wen || w_partial) begin
              w_csb[w_bank] = 1'b0;
              w_row         = w_row_in;
            end else if (w_full) begin
              w_csb[w_bank] = 1'b0;
              w_web         = 1'b0;
              w_row         = w_row_in;
              w_din         = PAD'(wdata);
            end
          end
        end
        S_RMW: begin
          w_csb[r_bank] = 1'b0;
          w_web         = 1'b0;
          w_row         = r_row;
          w_din         = PAD'(w_merge);
        end
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    for (genvar c = 0; c < NCOL; c++) begin : g_col
      mem_sp_tiled_sky130_macro #(
        .WIDTH (MACRO_WIDTH),
        .DEPTH (MACRO_DEPTH)
      ) u_macro (
        .clk  (clk),
        .csb  (w_csb[b]),
        .web  (w_web),
        .addr (w_row),
        .din  (w_din[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .dout (w_bank_dout[b][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_bank    <= '0;
      r_row     <= '0;
      r_wdata   <= '0;
      r_bwe     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_oob  <= 1'b0;
      req_rdy   <= 1'b0;
      rvld      <= 1'b0;
      rdata     <= '0;
      err_oob   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      rvld      <= 1'b0;
      err_oob   <= 1'b0;
      r_rd_pend <= 1'b0;
      if (r_rd_pend) begin
        rvld  <= 1'b1;
        rdata <= r_rd_oob ? '0 : w_dout_sel;
      end
      case (r_state)
        S_INIT: begin
          // Last row is written while r_cnt = MACRO_DEPTH-1; the handover edge follows.
          if (INIT_ZERO == 0 || r_cnt == c_rows) begin
            r_state   <= S_IDLE;
            req_rdy   <= 1'b1;
            init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_bank  <= w_bank;
            err_oob <= w_oob;
            if (!wen) begin
              r_rd_pend <= 1'b1;
              r_rd_oob  <= w_oob;
            end else if (!w_oob && w_partial) begin
              r_row   <= w_row_in;
              r_wdata <= wdata;
              r_bwe   <= bwe;
              r_state <= S_RMW;
              req_rdy <= 1'b0;
            end
          end
        end
        S_RMW: begin
          r_state <= S_IDLE;
          req_rdy <= 1'b1;
        end
        default: begin
          r_state <= S_INIT;
          r_cnt   <= '0;
          req_rdy <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_sp_tiled_sky130.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sp_tiled_sky130
// Purpose  : Directed plus randomized bench for mem_sp_tiled_sky130 against a
//            word-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_sp_tiled_sky130;
  localparam int DATA_BIT    = 64;
  localparam int DEPTH       = 300;
  localparam int MACRO_WIDTH = 32;
  localparam int MACRO_DEPTH = 128;
  localparam int ADDR_BIT    = 9;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_vld = 1'b0;
  logic                  req_rdy;
  logic                  wen = 1'b0;
  logic [ADDR_BIT-1:0]   addr = '0;
  logic [DATA_BIT-1:0]   wdata = '0;
  logic [DATA_BIT/8-1:0] bwe = '0;
  logic [DATA_BIT-1:0]   rdata;
  logic                  rvld;
  logic                  init_done;
  logic                  err_oob;

  int checks = 0;
  int errors = 0;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] last_rdata = '0;

  always #5 clk = ~clk;

  mem_sp_tiled_sky130 #(
    .DATA_BIT    (DATA_BIT),
    .DEPTH       (DEPTH),
    .MACRO_WIDTH (MACRO_WIDTH),
    .MACRO_DEPTH (MACRO_DEPTH),
    .ADDR_BIT    (ADDR_BIT),
    .INIT_ZERO   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .bwe       (bwe),
    .rdata     (rdata),
    .rvld      (rvld),
    .init_done (init_done),
    .err_oob   (err_oob)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_rdata = '0;
  endtask

  // Entered just after rst is released at a negedge.
  task automatic wait_init();
    int early = 0;
    for (int i = 0; i < MACRO_DEPTH; i++) begin
      @(negedge clk);
      if (init_done !== 1'b0 || req_rdy !== 1'b0) early++;
    end
    chk("init_early", 64'(early), 64'd0);
    @(negedge clk);
    chk("init_done", {63'd0, init_done}, 64'd1);
    chk("init_rdy", {63'd0, req_rdy}, 64'd1);
  endtask

  task automatic wait_rdy();
    int guard = 0;
    while (req_rdy !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("rdy_timeout", {63'd0, guard >= 300}, 64'd0);
  endtask

  // One request; returns at the negedge one cycle after its rvld slot.
  task automatic do_op(input logic w, input logic [ADDR_BIT-1:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    logic        oob;
    logic [63:0] exp;
    wait_rdy();
    req_vld = 1'b1; wen = w; addr = a; wdata = d; bwe = be;
    @(negedge clk);
    req_vld = 1'b0;
    oob = (int'(a) >= DEPTH);
    chk("err_oob", {63'd0, err_oob}, {63'd0, oob});
    exp = '0;
    if (!w) begin
      exp = oob ? 64'd0 : ref_mem[a];
    end else if (!oob) begin
      for (int j = 0; j < 8; j++)
        if (be[j]) ref_mem[a][j*8 +: 8] = d[j*8 +: 8];
    end
    @(negedge clk);
    chk("rvld", {63'd0, rvld}, {63'd0, !w});
    chk("err_oob_pulse", {63'd0, err_oob}, 64'd0);
    if (!w) begin
      chk("rdata", rdata, exp);
      last_rdata = exp;
    end else begin
      chk("rdata_hold", rdata, last_rdata);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_rdy", {63'd0, req_rdy}, 64'd0);
    chk("rst_rvld", {63'd0, rvld}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_oob", {63'd0, err_oob}, 64'd0);
    chk("rst_done", {63'd0, init_done}, 64'd0);
    rst = 1'b0;
    wait_init();

    do_op(1'b0, 9'd0, 64'd0, 8'h00);
    do_op(1'b0, 9'd255, 64'd0, 8'h00);
    do_op(1'b0, 9'd299, 64'd0, 8'h00);

    // Full-width writes then back-to-back reads with no stall.
    for (int i = 0; i < 8; i++)
      do_op(1'b1, 9'(i), 64'h1111_0000_0000_0000 + 64'(i), 8'hFF);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        chk("b2b_rvld", {63'd0, rvld}, 64'd1);
        chk("b2b_data", rdata, ref_mem[i-2]);
      end
      if (i < 8) begin
        chk("b2b_rdy", {63'd0, req_rdy}, 64'd1);
        req_vld = 1'b1; wen = 1'b0; addr = 9'(i);
      end else begin
        req_vld = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_rvld_end", {63'd0, rvld}, 64'd0);
    last_rdata = ref_mem[7];

    // Partial write into bank 1 with exactly one stall cycle.
    do_op(1'b1, 9'd130, 64'hAABBCCDD_11223344, 8'hFF);
    wait_rdy();
    req_vld = 1'b1; wen = 1'b1; addr = 9'd130; wdata = '1; bwe = 8'b0000_0101;
    @(negedge clk);
    req_vld = 1'b0;
    chk("rmw_stall", {63'd0, req_rdy}, 64'd0);
    @(negedge clk);
    chk("rmw_rdy_back", {63'd0, req_rdy}, 64'd1);
    chk("rmw_no_rvld", {63'd0, rvld}, 64'd0);
    ref_mem[130] = 64'hAABBCCDD_11FF33FF;
    do_op(1'b1, 9'd2, 64'h0000_0000_0000_0222, 8'hFF);
    do_op(1'b0, 9'd130, 64'd0, 8'h00);
    chk("rmw_value", last_rdata, 64'hAABBCCDD_11FF33FF);
    do_op(1'b0, 9'd2, 64'd0, 8'h00);

    // bwe=0 write leaves the word untouched and never stalls.
    do_op(1'b1, 9'd5, 64'h5, 8'hFF);
    wait_rdy();
    req_vld = 1'b1; wen = 1'b1; addr = 9'd5; wdata = '1; bwe = 8'h00;
    @(negedge clk);
    req_vld = 1'b0;
    chk("bwe0_no_stall", {63'd0, req_rdy}, 64'd1);
    @(negedge clk);
    do_op(1'b0, 9'd5, 64'd0, 8'h00);
    chk("bwe0_value", last_rdata, 64'h5);

    // Out-of-range read and write.
    do_op(1'b0, 9'd310, 64'd0, 8'h00);
    do_op(1'b1, 9'd400, 64'hDEAD, 8'hFF);

    // Randomized mix against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [ADDR_BIT-1:0] a;
      logic [7:0]          be;
      logic [63:0]         d;
      int                  sel;
      a   = 9'($urandom_range(0, 339));
      d   = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      do_op(1'($urandom_range(0, 1)), a, d, be);
    end

    // Reset during the RMW cycle: merge abandoned, fill redone.
    do_op(1'b1, 9'd9, 64'h0123_4567_89AB_CDEF, 8'hFF);
    wait_rdy();
    req_vld = 1'b1; wen = 1'b1; addr = 9'd9; wdata = '1; bwe = 8'h0F;
    @(negedge clk);
    req_vld = 1'b0;
    chk("rst_rmw_state", {63'd0, req_rdy}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_rvld", {63'd0, rvld}, 64'd0);
    chk("rst2_done", {63'd0, init_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    wait_init();
    chk("rst2_rdata", rdata, 64'd0);
    do_op(1'b0, 9'd9, 64'd0, 8'h00);
    do_op(1'b0, 9'd130, 64'd0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/mem_sp_tiled_sky130.md
Name: mem_sp_tiled_sky130

Overview:
- Parametrised single-port SRAM built as a grid of 1RW sky130 macros (MACRO_WIDTH x MACRO_DEPTH each): ceil(DATA_BIT/MACRO_WIDTH) columns by ceil(DEPTH/MACRO_DEPTH) row banks.
- Adds over the single-macro wrapper: valid/ready request handshake, byte-enable writes through an internal read-modify-write sequence, post-reset zero-fill, read-valid strobe and out-of-range flagging.
- Used as the generic weight/activation buffer in the accelerator memory subsystem.

Parameters:
- DATA_BIT, 64: word width; must be a multiple of 8.
- DEPTH, 512: number of words.
- MACRO_WIDTH, 32: macro data width; must be a multiple of 8. Unused top column bits are driven 0 and ignored.
- MACRO_DEPTH, 128: words per macro.
- ADDR_BIT, $clog2(DEPTH): address width.
- INIT_ZERO, 1: 1 = zero-fill the whole array after reset; 0 = skip the fill.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_vld  in  1  request valid
- req_rdy  out  1  block can accept a request
- wen  in  1  1 = write, 0 = read
- addr  in  ADDR_BIT  word address
- wdata  in  DATA_BIT  write data
- bwe  in  DATA_BIT/8  per-byte write enable
- rdata  out  DATA_BIT  read data; held between reads
- rvld  out  1  one-cycle pulse, rdata valid
- init_done  out  1  zero-fill complete (stays high)
- err_oob  out  1  one-cycle pulse on an accepted request with addr >= DEPTH

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Macro model: csb and web active-low; inputs sampled at posedge; array written and dout updated at the following negedge.
- Reset values: req_rdy=0, rvld=0, rdata=0, err_oob=0, init_done=0, state=INIT, fill counter=0, all macro csb=1.
- FSM states: INIT, IDLE, RMW.
- INIT (INIT_ZERO=1):
  - Writes 0 to row r of every macro in parallel, r = 0..MACRO_DEPTH-1, one row per cycle.
  - Moves to IDLE after row MACRO_DEPTH-1 is written.
  - init_done and req_rdy rise exactly MACRO_DEPTH cycles after the first posedge with rst low.
  - INIT_ZERO=0: go to IDLE at the first posedge with rst low.
- IDLE:
  - req_rdy=1. A request is accepted at a posedge where req_vld && req_rdy.
  - Request signals drive the macros combinationally, so the selected row bank samples at the accept edge. Bank = addr / MACRO_DEPTH, row = addr % MACRO_DEPTH.
  - Only the selected bank has csb=0; all other banks keep csb=1.
- Read accepted at edge T:
  - rdata is registered at T+1 from the selected bank's dout. The bank select is delayed one cycle for the mux.
  - rvld=1 for the cycle after T+1. Latency is 1 cycle.
  - Back-to-back reads sustain 1 per cycle.
- Write with bwe all ones: single-cycle write at T, no stall.
- Write with bwe all zeros: accepted with no macro access.
- Write with partial bwe:
  - At T: read issued to the macro; addr, wdata and bwe registered; state becomes RMW; req_rdy=0.
  - At T+1: macro write sampled with din = (dout & ~mask) | (wdata_q & mask), where mask is bwe expanded to bits; state returns to IDLE.
  - Throughput is one partial write per 2 cycles. rvld is not pulsed.
- Out-of-range request (addr >= DEPTH):
  - Accepted with no macro access; err_oob pulses for the cycle after acceptance.
  - A read also pulses rvld with rdata=0.
- rdata holds its last value until the next read completes.
- rst asserted mid-operation:
  - A pending RMW write is abandoned; no partial merge may reach the array.
  - rvld and err_oob drop; the FSM restarts INIT and the fill is redone.
- req_vld while req_rdy=0 is not accepted. The requester must hold the request stable until acceptance.

Test Plan:
- Reset then idle, INIT_ZERO=1, MACRO_DEPTH=128 -> init_done and req_rdy rise exactly 128 cycles after rst release; reads of addr 0, 255 and 511 return 0 with rvld one cycle after accept.
- Full-width writes to addr 0..7 (data 0x1111_0000_0000_0000 + i), then back-to-back reads -> rvld asserted on 8 consecutive cycles, data matches in order, no stall.
- Write 0xAABBCCDD_11223344 to addr 130 (bank 1), then partial write 0xFFFFFFFF_FFFFFFFF with bwe=8'b0000_0101 -> req_rdy low for exactly 1 cycle; readback 0xAABBCCDD_11FF33FF; a parallel write to addr 2 (bank 0) is unaffected.
- bwe=0 write to addr 5 (previously 0x5) -> accepted with no stall; readback stays 0x5.
- DEPTH=300, read addr 310 -> err_oob pulse and rvld with rdata=0; no macro csb goes low.
- rst asserted during the RMW cycle of a partial write to addr 9 -> after re-init, addr 9 reads 0 and init_done recovers after 128 cycles.
